calendar_set_ctrl: RTL and testbench

- Setting-mode controller for the calendar's five-field up-key demultiplexer. Turns raw push-buttons into its `mode[2:0]`, `on_off` and `key` inputs.
- Debounces buttons, sequences field selection, generates auto-repeat on the up key, and drops back to display mode after inactivity.
- Sits between the board buttons and the field up-key demux. Field counters are unchanged.

---
 rtl/calendar_set_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_calendar_set_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/calendar_set_ctrl.sv
// Setting-mode controller: debounces set/mode/up buttons, walks the five calendar
// fields, auto-repeats the up key, blinks the selected field and times out to display.
module calendar_set_ctrl #(
  parameter int DB_CYC      = 16,
  parameter int RPT_DELAY   = 64,
  parameter int RPT_RATE    = 16,
  parameter int TIMEOUT_CYC = 1024,
  parameter int BLINK_CYC   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_btn,
  input  logic       mode_btn,
  input  logic       up_btn,
  output logic [2:0] mode,
  output logic       on_off,
  output logic       key,
  output logic       blink,
  output logic [4:0] field_sel
);

  localparam int DBW     = $clog2(DB_CYC + 1);
  localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);
  localparam int BW      = $clog2(BLINK_CYC + 1);

  typedef enum logic {DISPLAY = 1'b0, EDIT = 1'b1} state_t;

  // Button bit order throughout: 0 = set, 1 = mode, 2 = up.
  logic [2:0]     raw, sync1, sync2, lvl, lvl_prev, press;
  logic [DBW-1:0] db_cnt [3];

  assign raw = {up_btn, mode_btn, set_btn};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      lvl      <= '0;
      lvl_prev <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      lvl_prev <= lvl;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != lvl[i]) begin
          if (db_cnt[i] == DBW'(DB_CYC - 1)) begin
            lvl[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DBW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = lvl & ~lvl_prev;

  // Same-clock presses: set beats mode beats up; losers are simply dropped.
  logic set_ev, mode_ev, up_ev;
  assign set_ev  = press[0];
  assign mode_ev = press[1] & ~press[0];
  assign up_ev   = press[2] & ~press[1] & ~press[0];

  state_t        state_q, state_d;
  logic [2:0]    field_q, field_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_active_q, rpt_active_d, rpt_first_q, rpt_first_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          key_q, key_d, blink_q, blink_d;
  logic [4:0]    field_sel_q, field_sel_d;
  logic          to_hit, stay_edit, entering, field_chg;

  assign to_hit = (to_cnt_q == TW'(TIMEOUT_CYC - 1)) && (press == 3'b000) && !lvl[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DISPLAY;
      field_q <= 3'd0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
    end
  end

  always_comb begin
    state_d = state_q;
    field_d = (field_q > 3'd4) ? 3'd0 : field_q;
    if (state_q == DISPLAY) begin
      field_d = 3'd0;
      if (set_ev) state_d = EDIT;
    end else begin
      if (set_ev || to_hit) begin
        state_d = DISPLAY;
        field_d = 3'd0;
      end else if (mode_ev) begin
        field_d = (field_d == 3'd4) ? 3'd0 : field_d + 3'd1;
      end
    end
  end

  assign stay_edit = (state_q == EDIT) && (state_d == EDIT);
  assign entering  = (state_q == DISPLAY) && (state_d == EDIT);
  assign field_chg = stay_edit && (field_d != field_q);

  always_comb begin
    key_d        = 1'b0;
    rpt_active_d = 1'b0;
    rpt_first_d  = 1'b0;
    rpt_cnt_d    = '0;
    to_cnt_d     = '0;
    blink_d      = 1'b0;
    blink_cnt_d  = '0;
    field_sel_d  = (state_d == EDIT) ? (5'b00001 << field_d) : 5'b00000;
    if (stay_edit) begin
      to_cnt_d = ((press != 3'b000) || lvl[2]) ? '0 : to_cnt_q + TW'(1);
      // Repeat survives only while up stays held and the field is unchanged.
      if (up_ev) begin
        key_d        = 1'b1;
        rpt_active_d = 1'b1;
        rpt_first_d  = 1'b1;
        rpt_cnt_d    = RW'(1);
      end else if (rpt_active_q && lvl[2] && !mode_ev) begin
        rpt_active_d = 1'b1;
        rpt_first_d  = rpt_first_q;
        if ((rpt_first_q && rpt_cnt_q == RW'(RPT_DELAY - 1)) ||
            (!rpt_first_q && rpt_cnt_q == RW'(RPT_RATE - 1))) begin
          key_d       = 1'b1;
          rpt_first_d = 1'b0;
          rpt_cnt_d   = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RW'(1);
        end
      end
      if (field_chg) begin
        blink_d = 1'b1;
      end else if (blink_cnt_q == BW'(BLINK_CYC - 1)) begin
        blink_d = ~blink_q;
      end else begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else if (entering) begin
      blink_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q     <= '0;
      rpt_cnt_q    <= '0;
      rpt_active_q <= 1'b0;
      rpt_first_q  <= 1'b0;
      blink_cnt_q  <= '0;
      key_q        <= 1'b0;
      blink_q      <= 1'b0;
      field_sel_q  <= 5'b00000;
    end else begin
      to_cnt_q     <= to_cnt_d;
      rpt_cnt_q    <= rpt_cnt_d;
      rpt_active_q <= rpt_active_d;
      rpt_first_q  <= rpt_first_d;
      blink_cnt_q  <= blink_cnt_d;
      key_q        <= key_d;
      blink_q      <= blink_d;
      field_sel_q  <= field_sel_d;
    end
  end

  assign mode      = field_q;
  assign on_off    = (state_q == EDIT);
  assign key       = key_q;
  assign blink     = blink_q;
  assign field_sel = field_sel_q;

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Bench for calendar_set_ctrl: table of button phases with expected outputs, plus
// hand sequences for bounce, up auto-repeat timing, timeout and mid-operation reset.
module tb_calendar_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       set_btn, mode_btn, up_btn;
  logic [2:0] mode;
  logic       on_off, key, blink;
  logic [4:0] field_sel;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic [31:0] exp_q[$];
  logic        key_prev = 1'b0;

  calendar_set_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_btn   (set_btn),
    .mode_btn  (mode_btn),
    .up_btn    (up_btn),
    .mode      (mode),
    .on_off    (on_off),
    .key       (key),
    .blink     (blink),
    .field_sel (field_sel)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       set_v;
    logic       mode_v;
    logic       up_v;
    int         ncyc;
    logic [2:0] e_mode;
    logic       e_on;
    logic [4:0] e_sel;
    logic       e_blink;
  } row_t;

  row_t rows[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic m, input logic u);
    set_btn  = s;
    mode_btn = m;
    up_btn   = u;
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] em, input logic eon,
                          input logic [4:0] esel, input logic ebl);
    chk({tag, "_mode"},      32'(mode),      32'(em));
    chk({tag, "_on_off"},    32'(on_off),    32'(eon));
    chk({tag, "_field_sel"}, 32'(field_sel), 32'(esel));
    chk({tag, "_blink"},     32'(blink),     32'(ebl));
  endtask

  task automatic apply_row(input int i);
    drive(rows[i].set_v, rows[i].mode_v, rows[i].up_v);
    wait_cyc(rows[i].ncyc);
    chk_outs($sformatf("row%0d", i), rows[i].e_mode, rows[i].e_on, rows[i].e_sel, rows[i].e_blink);
  endtask

  // scoreboard: every key pulse must match the next expected cycle, never two in a row
  always @(negedge clk) begin
    if (key) begin
      chk("key_double", 32'(key_prev), 32'd0);
      if (exp_q.size() == 0) chk("key_unexpected", 32'(key), 32'd0);
      else chk("key_cycle", cyc, exp_q.pop_front());
    end
    key_prev = key;
  end

  initial begin
    int c0;
    logic [3:0] bounce;
    // A press is processed 19 clocks after the drive; a press-pulse-relative
    // offset k therefore lands at drive cycle + 18 + k.
    rows[0]  = '{1'b0, 1'b1, 1'b0, 20, 3'd1, 1'b1, 5'b00010, 1'b1};
    rows[1]  = '{1'b0, 1'b0, 1'b0, 40, 3'd1, 1'b1, 5'b00010, 1'b0};
    rows[2]  = '{1'b0, 1'b1, 1'b0, 20, 3'd2, 1'b1, 5'b00100, 1'b1};
    rows[3]  = '{1'b0, 1'b0, 1'b0, 40, 3'd2, 1'b1, 5'b00100, 1'b0};
    rows[4]  = '{1'b0, 1'b1, 1'b0, 20, 3'd3, 1'b1, 5'b01000, 1'b1};
    rows[5]  = '{1'b0, 1'b0, 1'b0, 40, 3'd3, 1'b1, 5'b01000, 1'b0};
    rows[6]  = '{1'b0, 1'b1, 1'b0, 20, 3'd4, 1'b1, 5'b10000, 1'b1};
    rows[7]  = '{1'b0, 1'b0, 1'b0, 40, 3'd4, 1'b1, 5'b10000, 1'b0};
    rows[8]  = '{1'b0, 1'b1, 1'b0, 20, 3'd0, 1'b1, 5'b00001, 1'b1};
    rows[9]  = '{1'b0, 1'b0, 1'b0, 40, 3'd0, 1'b1, 5'b00001, 1'b0};
    rows[10] = '{1'b1, 1'b1, 1'b0, 20, 3'd0, 1'b0, 5'b00000, 1'b0};
    rows[11] = '{1'b0, 1'b0, 1'b0, 40, 3'd0, 1'b0, 5'b00000, 1'b0};
    rows[12] = '{1'b0, 1'b1, 1'b0, 20, 3'd0, 1'b0, 5'b00000, 1'b0};
    rows[13] = '{1'b0, 1'b0, 1'b0, 40, 3'd0, 1'b0, 5'b00000, 1'b0};
    rows[14] = '{1'b0, 1'b0, 1'b1, 100, 3'd0, 1'b0, 5'b00000, 1'b0};
    rows[15] = '{1'b0, 1'b0, 1'b0, 40, 3'd0, 1'b0, 5'b00000, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    wait_cyc(3);
    chk_outs("reset", 3'd0, 1'b0, 5'b00000, 1'b0);
    chk("reset_key", 32'(key), 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    // bouncy set press, then steady hold: exactly one entry to EDIT
    bounce = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      set_btn = bounce[i];
      wait_cyc(1);
    end
    drive(1'b1, 1'b0, 1'b0);
    wait_cyc(30);
    chk_outs("enter", 3'd0, 1'b1, 5'b00001, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    wait_cyc(30);
    chk_outs("enter_rel", 3'd0, 1'b1, 5'b00001, 1'b0);

    for (int i = 0; i < 10; i++) apply_row(i);

    // up held 140 clocks: pulses at +1,+64,+80,+96,+112 after the press pulse,
    // plus one at +128 while the release is still being debounced
    c0 = cyc;
    exp_q.push_back(32'(c0 + 19));
    exp_q.push_back(32'(c0 + 82));
    exp_q.push_back(32'(c0 + 98));
    exp_q.push_back(32'(c0 + 114));
    exp_q.push_back(32'(c0 + 130));
    exp_q.push_back(32'(c0 + 146));
    drive(1'b0, 1'b0, 1'b1);
    wait_cyc(140);
    chk("rpt_pending", 32'(exp_q.size()), 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    wait_cyc(40);
    chk("rpt_done", 32'(exp_q.size()), 32'd0);
    chk_outs("after_rpt", 3'd0, 1'b1, 5'b00001, blink);

    for (int i = 10; i < 16; i++) apply_row(i);

    // idle timeout: on_off high for exactly TIMEOUT_CYC clocks
    c0 = cyc;
    drive(1'b1, 1'b0, 1'b0);
    wait_cyc(20);
    chk("to_enter", 32'(on_off), 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    wait_cyc(c0 + 1042 - cyc);
    chk("to_before", 32'(on_off), 32'd1);
    wait_cyc(1);
    chk("to_at_limit", 32'(on_off), 32'd0);
    chk("to_mode", 32'(mode), 32'd0);
    wait_cyc(20);

    // up press near clock 1000 of EDIT defers the timeout by a full period
    c0 = cyc;
    drive(1'b1, 1'b0, 1'b0);
    wait_cyc(20);
    drive(1'b0, 1'b0, 1'b0);
    wait_cyc(979);
    chk("defer_pre", 32'(on_off), 32'd1);
    c0 = cyc;
    exp_q.push_back(32'(c0 + 19));
    drive(1'b0, 1'b0, 1'b1);
    wait_cyc(20);
    drive(1'b0, 1'b0, 1'b0);
    wait_cyc(25);
    chk("defer_orig_limit", 32'(on_off), 32'd1);
    wait_cyc(c0 + 1061 - cyc);
    chk("defer_before", 32'(on_off), 32'd1);
    wait_cyc(1);
    chk("defer_at_limit", 32'(on_off), 32'd0);
    wait_cyc(20);

    // reset mid-repeat with up held
    drive(1'b1, 1'b0, 1'b0);
    wait_cyc(20);
    drive(1'b0, 1'b0, 1'b0);
    wait_cyc(40);
    chk("rst_pre_on", 32'(on_off), 32'd1);
    c0 = cyc;
    exp_q.push_back(32'(c0 + 19));
    exp_q.push_back(32'(c0 + 82));
    drive(1'b0, 1'b0, 1'b1);
    wait_cyc(90);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 3'd0, 1'b0, 5'b00000, 1'b0);
    chk("async_rst_key", 32'(key), 32'd0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(60);
    chk_outs("post_rst", 3'd0, 1'b0, 5'b00000, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    wait_cyc(40);
    chk_outs("post_rst_rel", 3'd0, 1'b0, 5'b00000, 1'b0);
    chk("key_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
